// File: rtl/tbird_lights_param.sv
// Sequential turn / hazard / brake lamp controller with N_LAMPS per side and a built-in step prescaler.
// Latency: outputs are registered, so they change on the same edge as state; steps are TICK_DIV cycles long.
// Backpressure: none; level inputs are sampled every cycle, and turn requests are ignored until the FSM is back in IDLE.
module tbird_lights_param #(
    parameter int N_LAMPS  = 3,
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = $clog2(TICK_DIV + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               left,
    input  logic               right,
    input  logic               hazard,
    input  logic               brake,
    output logic [N_LAMPS-1:0] lights_l,
    output logic [N_LAMPS-1:0] lights_r,
    output logic               busy
);

    localparam int                 SW        = $clog2(N_LAMPS + 1);
    localparam logic [SW-1:0]      STEP_LAST = SW'(N_LAMPS);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [N_LAMPS-1:0] ALL_ON    = '1;

    typedef enum logic [2:0] {IDLE, LEFT, RIGHT, HAZ_ON, HAZ_OFF} state_t;

    state_t             state, state_nxt;
    logic [SW-1:0]      step, step_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [N_LAMPS-1:0] therm;
    logic [N_LAMPS-1:0] lights_l_nxt, lights_r_nxt;
    logic               tick;
    logic               haz_req;

    assign tick    = (cnt == CNT_LAST);
    assign haz_req = hazard | (left & right);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            step     <= '0;
            cnt      <= '0;
            lights_l <= '0;
            lights_r <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            step     <= step_nxt;
            cnt      <= cnt_nxt;
            lights_l <= lights_l_nxt;
            lights_r <= lights_r_nxt;
            busy     <= (state_nxt != IDLE);
        end
    end

    // Next state, step and prescaler; every state change also zeroes the prescaler.
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        cnt_nxt   = tick ? '0 : cnt + CNT_W'(1);
        case (state)
            IDLE: begin
                cnt_nxt  = '0;
                step_nxt = '0;
                if (haz_req) begin
                    state_nxt = HAZ_ON;
                end else if (left) begin
                    state_nxt = LEFT;
                    step_nxt  = SW'(1);
                end else if (right) begin
                    state_nxt = RIGHT;
                    step_nxt  = SW'(1);
                end
            end
            LEFT, RIGHT: begin
                if (haz_req) begin
                    state_nxt = HAZ_ON;
                    step_nxt  = '0;
                    cnt_nxt   = '0;
                end else if (tick) begin
                    if (step == STEP_LAST) begin
                        step_nxt = '0;
                    end else if (step == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        step_nxt = step + SW'(1);
                    end
                end
            end
            HAZ_ON: begin
                if (tick) state_nxt = HAZ_OFF;
            end
            HAZ_OFF: begin
                if (tick) state_nxt = haz_req ? HAZ_ON : IDLE;
            end
            default: begin
                state_nxt = IDLE;
                step_nxt  = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Lamp values are decoded from the next state so they land on the same edge.
    always_comb begin
        therm = '0;
        for (int i = 0; i < N_LAMPS; i++) begin
            therm[i] = (SW'(i) < step_nxt);
        end
        lights_l_nxt = '0;
        lights_r_nxt = '0;
        case (state_nxt)
            IDLE: begin
                if (brake) begin
                    lights_l_nxt = ALL_ON;
                    lights_r_nxt = ALL_ON;
                end
            end
            LEFT: begin
                lights_l_nxt = therm;
                lights_r_nxt = brake ? ALL_ON : '0;
            end
            RIGHT: begin
                lights_r_nxt = therm;
                lights_l_nxt = brake ? ALL_ON : '0;
            end
            HAZ_ON: begin
                lights_l_nxt = ALL_ON;
                lights_r_nxt = ALL_ON;
            end
            default: begin
                lights_l_nxt = '0;
                lights_r_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_tbird_lights_param.sv
// Directed bench for tbird_lights_param at N_LAMPS=3, TICK_DIV=4.
module tb_tbird_lights_param;

    logic       clk;
    logic       reset;
    logic       left, right, hazard, brake;
    logic [2:0] lights_l, lights_r;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    tbird_lights_param #(.N_LAMPS(3), .TICK_DIV(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .left     (left),
        .right    (right),
        .hazard   (hazard),
        .brake    (brake),
        .lights_l (lights_l),
        .lights_r (lights_r),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] l, input logic [2:0] r, input logic b);
        chk({tag, ".l"}, {29'd0, lights_l}, {29'd0, l});
        chk({tag, ".r"}, {29'd0, lights_r}, {29'd0, r});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    endtask

    // Advance n active edges and sample 1 time unit later.
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; left = 1'b1; right = 1'b1; hazard = 1'b1; brake = 1'b1;
        #2 reset = 1'b0;
        #1 chk_all("rst_immediate", 3'b000, 3'b000, 1'b0);
        edges(3);
        chk_all("rst_held", 3'b000, 3'b000, 1'b0);
        left = 1'b0; right = 1'b0; hazard = 1'b0; brake = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Left sequence, request held one cycle.
        left = 1'b1;
        edges(1);
        chk_all("left_e0", 3'b001, 3'b000, 1'b1);
        left = 1'b0;
        edges(3);
        chk_all("left_e3", 3'b001, 3'b000, 1'b1);
        edges(1);
        chk_all("left_e4", 3'b011, 3'b000, 1'b1);
        edges(4);
        chk_all("left_e8", 3'b111, 3'b000, 1'b1);
        edges(4);
        chk_all("left_e12_gap", 3'b000, 3'b000, 1'b1);
        edges(3);
        chk_all("left_e15", 3'b000, 3'b000, 1'b1);
        edges(1);
        chk_all("left_e16_idle", 3'b000, 3'b000, 1'b0);

        // Hazard aborting a left sequence.
        left = 1'b1;
        edges(1);
        left = 1'b0;
        edges(5);
        chk_all("abort_e5", 3'b011, 3'b000, 1'b1);
        hazard = 1'b1;
        edges(1);
        chk_all("abort_e6_on", 3'b111, 3'b111, 1'b1);
        edges(3);
        chk_all("abort_e9_on", 3'b111, 3'b111, 1'b1);
        edges(1);
        chk_all("abort_e10_off", 3'b000, 3'b000, 1'b1);
        edges(4);
        chk_all("abort_e14_on", 3'b111, 3'b111, 1'b1);
        hazard = 1'b0;
        edges(4);
        chk_all("abort_e18_off", 3'b000, 3'b000, 1'b1);
        edges(4);
        chk_all("abort_e22_idle", 3'b000, 3'b000, 1'b0);

        // Left and right together act as hazard.
        left = 1'b1; right = 1'b1;
        edges(1);
        chk_all("both_on", 3'b111, 3'b111, 1'b1);
        left = 1'b0; right = 1'b0;
        edges(4);
        chk_all("both_off", 3'b000, 3'b000, 1'b1);
        edges(4);
        chk_all("both_idle", 3'b000, 3'b000, 1'b0);

        // Brake overlay in IDLE and on a right sequence.
        brake = 1'b1;
        edges(1);
        chk_all("brake_idle", 3'b111, 3'b111, 1'b0);
        right = 1'b1;
        edges(1);
        chk_all("brake_r_e0", 3'b111, 3'b001, 1'b1);
        right = 1'b0;
        edges(4);
        chk_all("brake_r_e4", 3'b111, 3'b011, 1'b1);
        edges(4);
        chk_all("brake_r_e8", 3'b111, 3'b111, 1'b1);
        edges(4);
        chk_all("brake_r_e12", 3'b111, 3'b000, 1'b1);
        edges(4);
        chk_all("brake_r_idle", 3'b111, 3'b111, 1'b0);

        // Brake has no effect during hazard.
        hazard = 1'b1;
        edges(1);
        chk_all("brake_haz_on", 3'b111, 3'b111, 1'b1);
        hazard = 1'b0;
        edges(4);
        chk_all("brake_haz_off", 3'b000, 3'b000, 1'b1);
        edges(4);
        chk_all("brake_haz_idle", 3'b111, 3'b111, 1'b0);
        brake = 1'b0;
        edges(1);
        chk_all("brake_release", 3'b000, 3'b000, 1'b0);

        // Asynchronous reset in the middle of a right sequence.
        right = 1'b1;
        edges(1);
        chk_all("mid_r_e0", 3'b000, 3'b001, 1'b1);
        right = 1'b0;
        edges(4);
        chk_all("mid_r_e4", 3'b000, 3'b011, 1'b1);
        #2 reset = 1'b0;
        #1 chk_all("mid_rst_async", 3'b000, 3'b000, 1'b0);
        @(negedge clk);
        right = 1'b1;
        reset = 1'b1;
        edges(1);
        chk_all("restart_e0", 3'b000, 3'b001, 1'b1);
        right = 1'b0;
        edges(3);
        chk_all("restart_e3", 3'b000, 3'b001, 1'b1);
        edges(1);
        chk_all("restart_e4", 3'b000, 3'b011, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
